// File: rtl/disp_pkg.sv
// Shared definitions for the display page scheduler.
// Contents: FSM state encodings, digit code constants and value/nibble widths.
// Digit code format: bit4 = blank, bits3:0 = hex nibble.
package disp_pkg;

  localparam int unsigned NIBBLE_W = 4;
  localparam int unsigned VALUE_W  = 16;
  localparam int unsigned DIGIT_W  = NIBBLE_W + 1;
  localparam int unsigned NUM_DIG  = VALUE_W / NIBBLE_W;

  localparam logic [DIGIT_W-1:0] DIGIT_BLANK = 5'b10000;

  // Encoding 2'd3 is unused; the FSM steers it back to StAuto.
  typedef enum logic [1:0] {
    StAuto     = 2'd0,
    StHold     = 2'd1,
    StOverride = 2'd2
  } state_e;

  // Visible (non-blank) digit code for one nibble.
  function automatic logic [DIGIT_W-1:0] digit_code(input logic [NIBBLE_W-1:0] nib);
    return {1'b0, nib};
  endfunction

endpackage

// File: rtl/disp_btn_edge.sv
// Registered rising-edge detector for one debounced button level.
// Ports:
//   i_clk  - system clock
//   i_rst  - synchronous active-high reset (clears the previous-level register)
//   i_btn  - debounced button level
//   o_edge - high for the single cycle where i_btn is high and was low last cycle
module disp_btn_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_edge
);

  logic r_btn_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_btn_prev <= 1'b0;
    end else begin
      r_btn_prev <= i_btn;
    end
  end

  assign o_edge = i_btn & ~r_btn_prev;

endmodule

// File: rtl/display_page_scheduler.sv
// Shares the 4-digit seven-segment display between NUM_SRC paged debug sources and one
// priority override requester. Pages advance on a timer (AUTO) or on next_btn (HOLD/AUTO).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero nibbles (AN0 always shown).
// Ports:
//   clk100M, rst           - clock, synchronous active-high reset
//   src_data, src_valid    - packed 16-bit source values and their valid flags
//   mode_btn, next_btn     - debounced button levels (rising edge acts)
//   ovr_req, ovr_data      - override request level and value (sampled on accept)
//   ovr_ack                - one-cycle pulse when an override is accepted
//   AN3..AN0               - registered digit codes, AN3 = most-significant nibble
//   page, state            - current source index and FSM state encoding
module display_page_scheduler
  import disp_pkg::*;
#(
  parameter int unsigned NUM_SRC    = 4,
  parameter int unsigned PAGE_TICKS = 100000000,
  parameter int unsigned OVR_TICKS  = 50000000,
  parameter int unsigned TICK_W     = 27
) (
  input  logic                         clk100M,
  input  logic                         rst,
  input  logic [NUM_SRC*VALUE_W-1:0]   src_data,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic                         mode_btn,
  input  logic                         next_btn,
  input  logic                         ovr_req,
  input  logic [VALUE_W-1:0]           ovr_data,
  output logic                         ovr_ack,
  output logic [DIGIT_W-1:0]           AN3,
  output logic [DIGIT_W-1:0]           AN2,
  output logic [DIGIT_W-1:0]           AN1,
  output logic [DIGIT_W-1:0]           AN0,
  output logic [$clog2(NUM_SRC)-1:0]   page,
  output logic [1:0]                   state
);

  localparam int unsigned PageW = $clog2(NUM_SRC);

  state_e                           r_state, w_state_d;
  state_e                           r_saved, w_saved_d;
  logic [PageW-1:0]                 r_page, w_page_d, w_page_inc;
  logic [TICK_W-1:0]                r_tick, w_tick_d;
  logic [VALUE_W-1:0]               r_ovr_val, w_ovr_val_d;
  logic                             r_ack, w_ack_d;
  logic [NUM_DIG-1:0][DIGIT_W-1:0]  r_an, w_codes;

  logic                             w_mode_edge, w_next_edge, w_accept;
  logic [VALUE_W-1:0]               w_src [NUM_SRC];
  logic [NUM_DIG-1:0][NIBBLE_W-1:0] w_val;
  logic                             w_disp_on;
`ifdef LEADING_ZERO_BLANK_EN
  logic                             w_lead;
`endif

  disp_btn_edge u_mode_edge (
    .i_clk  (clk100M),
    .i_rst  (rst),
    .i_btn  (mode_btn),
    .o_edge (w_mode_edge)
  );

  disp_btn_edge u_next_edge (
    .i_clk  (clk100M),
    .i_rst  (rst),
    .i_btn  (next_btn),
    .o_edge (w_next_edge)
  );

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    assign w_src[g] = src_data[g*VALUE_W +: VALUE_W];
  end

  assign w_page_inc = r_page + PageW'(1);
  assign w_accept   = ovr_req && ((r_state == StAuto) || (r_state == StHold));

  // Next-state logic. Override acceptance wins over any button edge in the same cycle.
  always_comb begin
    w_state_d   = r_state;
    w_saved_d   = r_saved;
    w_page_d    = r_page;
    w_tick_d    = r_tick;
    w_ovr_val_d = r_ovr_val;
    w_ack_d     = 1'b0;
    if (w_accept) begin
      w_saved_d   = r_state;
      w_ovr_val_d = ovr_data;
      w_tick_d    = '0;
      w_state_d   = StOverride;
      w_ack_d     = 1'b1;
    end else begin
      case (r_state)
        StAuto: begin
          if (w_next_edge) begin
            w_page_d = w_page_inc;
            w_tick_d = '0;
          end else if (!w_mode_edge) begin
            if (r_tick == TICK_W'(PAGE_TICKS - 1)) begin
              w_tick_d = '0;
              w_page_d = w_page_inc;
            end else begin
              w_tick_d = r_tick + TICK_W'(1);
            end
          end
          // Leaving for HOLD freezes the tick where it stands.
          if (w_mode_edge) begin
            w_state_d = StHold;
          end
        end
        StHold: begin
          if (w_next_edge) begin
            w_page_d = w_page_inc;
          end
          if (w_mode_edge) begin
            w_state_d = StAuto;
            w_tick_d  = '0;
          end
        end
        StOverride: begin
          if (r_tick == TICK_W'(OVR_TICKS - 1)) begin
            w_tick_d  = '0;
            w_state_d = r_saved;
          end else begin
            w_tick_d = r_tick + TICK_W'(1);
          end
        end
        default: begin
          w_state_d = StAuto;
          w_tick_d  = '0;
        end
      endcase
    end
  end

  // Digit codes for the value currently selected for display.
  always_comb begin
    w_codes   = {NUM_DIG{DIGIT_BLANK}};
    w_disp_on = (r_state == StOverride) || src_valid[r_page];
    w_val     = (r_state == StOverride) ? r_ovr_val : w_src[r_page];
`ifdef LEADING_ZERO_BLANK_EN
    w_lead    = 1'b1;
`endif
    if (w_disp_on) begin
      for (int i = 0; i < NUM_DIG; i++) begin
        w_codes[i] = digit_code(w_val[i]);
      end
`ifdef LEADING_ZERO_BLANK_EN
      // Blank from the top digit down until the first non-zero nibble; digit 0 never blanks.
      for (int i = NUM_DIG - 1; i >= 1; i--) begin
        if (w_lead && (w_val[i] == '0)) begin
          w_codes[i] = DIGIT_BLANK;
        end else begin
          w_lead = 1'b0;
        end
      end
`endif
    end
  end

  always_ff @(posedge clk100M) begin
    if (rst) begin
      r_state   <= StAuto;
      r_saved   <= StAuto;
      r_page    <= '0;
      r_tick    <= '0;
      r_ovr_val <= '0;
      r_ack     <= 1'b0;
      r_an      <= {NUM_DIG{DIGIT_BLANK}};
    end else begin
      r_state   <= w_state_d;
      r_saved   <= w_saved_d;
      r_page    <= w_page_d;
      r_tick    <= w_tick_d;
      r_ovr_val <= w_ovr_val_d;
      r_ack     <= w_ack_d;
      r_an      <= w_codes;
    end
  end

  assign ovr_ack = r_ack;
  assign AN3     = r_an[3];
  assign AN2     = r_an[2];
  assign AN1     = r_an[1];
  assign AN0     = r_an[0];
  assign page    = r_page;
  assign state   = r_state;

endmodule
